cb_drain: RTL and testbench
===========================

# cb_drain

Read-side controller for the 2-wide circular buffer `cb`. Each cycle it issues `dout1_req`/`dout2_req` pops from the buffer head and captures the popped entries into a 2-slot holding stage. It then serialises them, oldest first, onto a single-wide valid/ready stream toward the downstream consumer. It is the consumer-side counterpart of the producer logic that drives `din1_en`/`din2_en`, and it never pops an entry it cannot hold.

## Interface
- `CB_WIDTH`, 8, entry width; must match the attached `cb`.
- `clk`  in  1  sole clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; low clears all state immediately.
- `flush`  in  1  synchronous discard of the holding stage; blocks pops in the same cycle.
- `cb_empty`  in  1  `cb` holds 0 entries.
- `cb_empty_almost`  in  1  `cb` holds exactly 1 entry.
- `cb_dout1`  in  CB_WIDTH  `cb` head entry, combinational from `cb`.
- `cb_dout2`  in  CB_WIDTH  `cb` head+1 entry, combinational from `cb`.
- `cb_dout1_req`  out  1  pop head at next rising edge.
- `cb_dout2_req`  out  1  pop head+1 at next rising edge; never high without `cb_dout1_req`.
- `out_valid`  out  1  `out_data` holds a valid entry.
- `out_data`  out  CB_WIDTH  oldest held entry.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `hold_count`  out  2  entries in the holding stage, 0..2.

## Operation
- The holding stage has `slot0` (oldest) and `slot1`. An FSM tracks occupancy with states HOLD0, HOLD1 and HOLD2, encoded as `hold_count` = 0/1/2.
- `out_valid = (hold_count != 0)` and `out_data = slot0`. Both come straight from registers.
- A transfer (`xfer`) occurs when `out_valid & out_ready`.
- `space = 2 - hold_count + xfer`. The range is 0..2, since HOLD2 with `xfer` gives 1.
- `avail = cb_empty ? 0 : cb_empty_almost ? 1 : 2`.
- `npop = flush ? 0 : min(space, avail)`.
- `cb_dout1_req = (npop >= 1)` and `cb_dout2_req = (npop == 2)`. Both are combinational, and both are forced to 0 while `reset` is low.
- Next-state ordering:
  - Remove `slot0` if `xfer`, shifting `slot1` down.
  - Then append `cb_dout1`, then `cb_dout2`, as far as `npop` allows.
  - New count is `hold_count - xfer + npop`, always ≤ 2.
- Transitions:
  - HOLD0 → HOLD0/1/2 by `npop`.
  - HOLD1 → HOLD0..2 by `npop - xfer`.
  - HOLD2 → HOLD1 on `xfer` with no pop.
  - HOLD2 stays in HOLD2 on `xfer` with a pop, or on no `xfer`.
- `flush`: next `hold_count` = 0, and slot contents are don't-care. An `xfer` in the flush cycle still counts as accepted by the consumer. No pops are issued.
- Entries are delivered in exact `cb` order with no duplication or loss. Wrap-around of the `cb` head is invisible to this block.
- If `cb_empty` and `cb_empty_almost` are both high (illegal input), treat it as empty.

## Timing
- Reset values: `hold_count` = 0, `slot0`/`slot1` = 0, `out_valid` = 0, `out_data` = 0, both reqs = 0.
- Reset deassertion is synchronised to `clk` by the environment. The first pop can occur at the first rising edge after `reset` goes high.
- Latency: an entry popped at edge N appears on `out_data` with `out_valid`=1 immediately after edge N. Buffer head to consumer is 1 cycle.
- Throughput: sustained 1 entry/cycle with `out_ready` held high and `cb` non-empty. The stage refills the freed slot in the same edge.
- Back-pressure: with `out_ready` low in HOLD2, both reqs stay 0 and `out_data` is held stable. `out_data` may not change while `out_valid & !out_ready`.
- Reset asserted mid-operation: state clears asynchronously, and held entries are lost.
- `cb_dout*` must settle before the edge. The req outputs depend combinationally on `out_ready`, `flush` and the `cb` status inputs.

## Test plan
- Reset, then a buffer with 0xA1, 0xA2, 0xA3 and `out_ready`=0 → first edge pops 2 (both reqs high), `hold_count`=2, `out_data`=0xA1; further edges issue no reqs.
- From that state, raise `out_ready` → one edge per value: `out_data` reads 0xA1, 0xA2, 0xA3 on consecutive cycles. The pop of 0xA3 coincides with the first `xfer`, `out_valid` drops after 0xA3, and the buffer ends empty.
- Buffer with a single entry 0x05 (`cb_empty_almost`) in HOLD0 → only `cb_dout1_req`, `hold_count`=1, `out_data`=0x05 next cycle.
- Stream 0x01..0x10 with `out_ready` toggling 1,0,1,0 → consumer receives 0x01..0x10 in order with no gaps or repeats. `cb_dout2_req` is never high without `cb_dout1_req`.
- `flush` in HOLD2 (0x33, 0x44) with a non-empty buffer → no reqs that cycle, `hold_count`=0 and `out_valid`=0 after the edge, and the next buffer entry follows normally.
- Assert `reset` low between edges while in HOLD2 → `out_valid`, `hold_count` and the reqs go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/cb_drain_if.sv
// Groups the cb read port and the downstream single-wide stream of cb_drain.
// master: the drain block (drives pop requests and the output stream).
// slave: the environment side (cb status and data, consumer ready).
interface cb_drain_if #(
    parameter int CB_WIDTH = 8
);
    // cb side
    logic                cb_empty;
    logic                cb_empty_almost;
    logic [CB_WIDTH-1:0] cb_dout1;
    logic [CB_WIDTH-1:0] cb_dout2;
    logic                cb_dout1_req;
    logic                cb_dout2_req;
    // consumer side
    logic                out_valid;
    logic [CB_WIDTH-1:0] out_data;
    logic                out_ready;

    modport master (
        input  cb_empty,
        input  cb_empty_almost,
        input  cb_dout1,
        input  cb_dout2,
        output cb_dout1_req,
        output cb_dout2_req,
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        output cb_empty,
        output cb_empty_almost,
        output cb_dout1,
        output cb_dout2,
        input  cb_dout1_req,
        input  cb_dout2_req,
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/cb_drain.sv
// Pops up to 2 entries/cycle from cb into a 2-slot holding stage and serialises them oldest first.
// Latency: entry popped at edge N is on out_data right after edge N; 1 entry/cycle sustained.
// Backpressure: out_ready low holds out_data stable; pops are limited to free slots, none when full.
module cb_drain #(
    parameter int CB_WIDTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    output logic [1:0] hold_count,
    cb_drain_if.master bus
);

    typedef enum logic [1:0] {
        HOLD0 = 2'd0,
        HOLD1 = 2'd1,
        HOLD2 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CB_WIDTH-1:0] slot0;
    logic [CB_WIDTH-1:0] slot1;
    logic [CB_WIDTH-1:0] slot0_nxt;
    logic [CB_WIDTH-1:0] slot1_nxt;

    logic       xfer;
    logic [1:0] cnt;
    logic [1:0] space;
    logic [1:0] avail;
    logic [1:0] npop;
    logic [1:0] kept;

    assign cnt        = state;
    assign hold_count = cnt;

    // Outputs come directly from the state and slot registers.
    assign bus.out_valid = (state != HOLD0);
    assign bus.out_data  = slot0;

    assign xfer = bus.out_valid & bus.out_ready;

    // Free room after this cycle's transfer; a full stage that hands one off
    // can take one new entry in the same edge, which gives full throughput.
    assign space = 2'd2 - cnt + {1'b0, xfer};

    // Both status flags high is not a legal cb state; treat it as empty.
    assign avail = bus.cb_empty        ? 2'd0 :
                   bus.cb_empty_almost ? 2'd1 : 2'd2;

    assign npop = flush ? 2'd0 : ((space < avail) ? space : avail);

    // Pop requests are combinational and held off entirely while in reset.
    assign bus.cb_dout1_req = reset & (npop != 2'd0);
    assign bus.cb_dout2_req = reset & (npop == 2'd2);

    // Entries that survive the transfer in this cycle.
    assign kept = cnt - {1'b0, xfer};

    // State register for the occupancy FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= HOLD0;
        end else begin
            state <= state_nxt;
        end
    end

    // Occupancy transitions: remove on transfer, then add the popped entries.
    always_comb begin
        state_nxt = state;
        case (state)
            HOLD0:   state_nxt = state_t'(npop);
            HOLD1:   state_nxt = state_t'(kept + npop);
            HOLD2:   state_nxt = (xfer && (npop == 2'd0)) ? HOLD1 : HOLD2;
            default: state_nxt = HOLD0;
        endcase
        if (flush) begin
            state_nxt = HOLD0;
        end
    end

    // Slot next values: shift slot1 down on transfer, then append cb_dout1
    // and cb_dout2 behind whatever is still held.
    always_comb begin
        slot0_nxt = xfer ? slot1 : slot0;
        slot1_nxt = slot1;
        if (npop != 2'd0) begin
            if (kept == 2'd0) begin
                slot0_nxt = bus.cb_dout1;
            end else begin
                slot1_nxt = bus.cb_dout1;
            end
        end
        if (npop == 2'd2) begin
            // Two pops only happen into an empty stage.
            slot1_nxt = bus.cb_dout2;
        end
    end

    // Holding stage data registers; contents after a flush are don't-care.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            slot0 <= slot0_nxt;
            slot1 <= slot1_nxt;
        end
    end

endmodule

// File: tb/tb_cb_drain.sv
// Directed bench for cb_drain with a small queue model of the attached cb.
// Outputs sampled 1ns after the rising edge; inputs changed there too.
// Each task checks its scenario inline against hand-computed values.
module tb_cb_drain;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [1:0] hold_count;

    cb_drain_if #(.CB_WIDTH(8)) bus ();

    cb_drain #(.CB_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .hold_count (hold_count),
        .bus        (bus.master)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] cbq[$];
    logic       illegal = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive cb status/data from the queue model.
    task automatic update_cb();
        if (illegal) begin
            bus.cb_empty        = 1'b1;
            bus.cb_empty_almost = 1'b1;
        end else begin
            bus.cb_empty        = (cbq.size() == 0);
            bus.cb_empty_almost = (cbq.size() == 1);
        end
        bus.cb_dout1 = (cbq.size() > 0) ? cbq[0] : 8'h00;
        bus.cb_dout2 = (cbq.size() > 1) ? cbq[1] : 8'h00;
    endtask

    // One clock: sample requests before the edge, pop the model after it.
    task automatic step();
        logic r1, r2;
        #1;
        r1 = bus.cb_dout1_req;
        r2 = bus.cb_dout2_req;
        @(posedge clk);
        #1;
        if (r1 && cbq.size() > 0) void'(cbq.pop_front());
        if (r2 && cbq.size() > 0) void'(cbq.pop_front());
        update_cb();
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        cbq = '{8'hA1, 8'hA2, 8'hA3};
        update_cb();
        #2;
        total++; if (bus.cb_dout1_req !== 1'b0) begin bad++; $display("FAIL reset_req1 got=%b exp=0", bus.cb_dout1_req); end
        total++; if (bus.cb_dout2_req !== 1'b0) begin bad++; $display("FAIL reset_req2 got=%b exp=0", bus.cb_dout2_req); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.out_valid); end
        total++; if (hold_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", hold_count); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", bus.out_data); end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_pop2();
        #1;
        total++; if (bus.cb_dout1_req !== 1'b1) begin bad++; $display("FAIL pop2_req1 got=%b exp=1", bus.cb_dout1_req); end
        total++; if (bus.cb_dout2_req !== 1'b1) begin bad++; $display("FAIL pop2_req2 got=%b exp=1", bus.cb_dout2_req); end
        step();
        total++; if (hold_count !== 2'd2) begin bad++; $display("FAIL pop2_count got=%0d exp=2", hold_count); end
        total++; if (bus.out_data !== 8'hA1) begin bad++; $display("FAIL pop2_data got=%h exp=a1", bus.out_data); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL pop2_valid got=%b exp=1", bus.out_valid); end
        for (int i = 0; i < 2; i++) begin
            #1;
            total++; if (bus.cb_dout1_req !== 1'b0) begin bad++; $display("FAIL full_noreq got=%b exp=0", bus.cb_dout1_req); end
            step();
            total++; if (bus.out_data !== 8'hA1) begin bad++; $display("FAIL full_stable got=%h exp=a1", bus.out_data); end
        end
    endtask

    task automatic test_drain();
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.cb_dout1_req !== 1'b1 || bus.cb_dout2_req !== 1'b0) begin bad++; $display("FAIL drain_req got=%b%b exp=10", bus.cb_dout1_req, bus.cb_dout2_req); end
        step();
        total++; if (bus.out_data !== 8'hA2 || hold_count !== 2'd2) begin bad++; $display("FAIL drain_a2 got=%h/%0d exp=a2/2", bus.out_data, hold_count); end
        total++; if (cbq.size() != 0) begin bad++; $display("FAIL drain_cb_empty got=%0d exp=0", cbq.size()); end
        step();
        total++; if (bus.out_data !== 8'hA3 || hold_count !== 2'd1) begin bad++; $display("FAIL drain_a3 got=%h/%0d exp=a3/1", bus.out_data, hold_count); end
        step();
        total++; if (bus.out_valid !== 1'b0 || hold_count !== 2'd0) begin bad++; $display("FAIL drain_done got=%b/%0d exp=0/0", bus.out_valid, hold_count); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_single();
        cbq = '{8'h05};
        update_cb();
        #1;
        total++; if (bus.cb_dout1_req !== 1'b1 || bus.cb_dout2_req !== 1'b0) begin bad++; $display("FAIL single_req got=%b%b exp=10", bus.cb_dout1_req, bus.cb_dout2_req); end
        step();
        total++; if (bus.out_data !== 8'h05 || hold_count !== 2'd1) begin bad++; $display("FAIL single_data got=%h/%0d exp=05/1", bus.out_data, hold_count); end
        bus.out_ready = 1'b1;
        step();
        total++; if (hold_count !== 2'd0) begin bad++; $display("FAIL single_drain got=%0d exp=0", hold_count); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_stream();
        logic [7:0] rcv[$];
        int cyc;
        for (int v = 1; v <= 16; v++) cbq.push_back(8'(v));
        update_cb();
        cyc = 0;
        while (rcv.size() < 16 && cyc < 200) begin
            bus.out_ready = (cyc % 2 == 0);
            #1;
            if (bus.cb_dout2_req && !bus.cb_dout1_req) begin
                total++; bad++; $display("FAIL stream_req2_alone cycle=%0d", cyc);
            end
            if (bus.out_valid && bus.out_ready) rcv.push_back(bus.out_data);
            step();
            cyc++;
        end
        total++; if (rcv.size() != 16) begin bad++; $display("FAIL stream_timeout got=%0d exp=16", rcv.size()); end
        for (int i = 0; i < rcv.size(); i++) begin
            total++; if (rcv[i] !== 8'(i + 1)) begin bad++; $display("FAIL stream_order idx=%0d got=%h exp=%h", i, rcv[i], 8'(i + 1)); end
        end
        bus.out_ready = 1'b0;
        #1;
        total++; if (hold_count !== 2'd0) begin bad++; $display("FAIL stream_end_count got=%0d exp=0", hold_count); end
    endtask

    task automatic test_flush();
        cbq = '{8'h33, 8'h44, 8'h55};
        update_cb();
        step();
        total++; if (hold_count !== 2'd2 || bus.out_data !== 8'h33) begin bad++; $display("FAIL flush_fill got=%0d/%h exp=2/33", hold_count, bus.out_data); end
        flush = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        total++; if (bus.cb_dout1_req !== 1'b0 || bus.cb_dout2_req !== 1'b0) begin bad++; $display("FAIL flush_req got=%b%b exp=00", bus.cb_dout1_req, bus.cb_dout2_req); end
        step();
        flush = 1'b0;
        bus.out_ready = 1'b0;
        total++; if (hold_count !== 2'd0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_clear got=%0d/%b exp=0/0", hold_count, bus.out_valid); end
        #1;
        total++; if (bus.cb_dout1_req !== 1'b1 || bus.cb_dout2_req !== 1'b0) begin bad++; $display("FAIL flush_next_req got=%b%b exp=10", bus.cb_dout1_req, bus.cb_dout2_req); end
        step();
        total++; if (bus.out_data !== 8'h55 || hold_count !== 2'd1) begin bad++; $display("FAIL flush_next got=%h/%0d exp=55/1", bus.out_data, hold_count); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_illegal();
        cbq = '{8'h99};
        illegal = 1'b1;
        update_cb();
        #1;
        total++; if (bus.cb_dout1_req !== 1'b0) begin bad++; $display("FAIL illegal_req got=%b exp=0", bus.cb_dout1_req); end
        step();
        total++; if (hold_count !== 2'd0) begin bad++; $display("FAIL illegal_count got=%0d exp=0", hold_count); end
        illegal = 1'b0;
        cbq.delete();
        update_cb();
    endtask

    task automatic test_async_reset();
        cbq = '{8'h66, 8'h77, 8'h88};
        update_cb();
        step();
        total++; if (hold_count !== 2'd2) begin bad++; $display("FAIL areset_fill got=%0d exp=2", hold_count); end
        #2;
        reset = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || hold_count !== 2'd0) begin bad++; $display("FAIL areset_clear got=%b/%0d exp=0/0", bus.out_valid, hold_count); end
        total++; if (bus.cb_dout1_req !== 1'b0 || bus.cb_dout2_req !== 1'b0) begin bad++; $display("FAIL areset_req got=%b%b exp=00", bus.cb_dout1_req, bus.cb_dout2_req); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        total++; if (bus.cb_dout1_req !== 1'b1 || bus.cb_dout2_req !== 1'b0) begin bad++; $display("FAIL areset_resume_req got=%b%b exp=10", bus.cb_dout1_req, bus.cb_dout2_req); end
        step();
        total++; if (bus.out_data !== 8'h88 || hold_count !== 2'd1) begin bad++; $display("FAIL areset_resume got=%h/%0d exp=88/1", bus.out_data, hold_count); end
    endtask

    initial begin
        test_reset();
        test_pop2();
        test_drain();
        test_single();
        test_stream();
        test_flush();
        test_illegal();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
